// File: rtl/uart_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_imem_loader
// Purpose  : UART boot loader in front of the instruction memory. Receives a
//            framed program image (SYNC, LEN_LO, LEN_HI, LEN*4 data bytes,
//            CSUM) on uart_rx, packs little-endian 32-bit words and writes
//            them through the imem write port. Keeps the core held in reset
//            until a complete frame with a matching checksum has arrived.
// Ports    : clk        in   clock
//            rst_n      in   synchronous active-low reset
//            uart_rx    in   async serial input, idle high, 8N1, LSB first
//            core_hold  out  1 = keep core/imem in reset
//            wstrb      out  4'b1111 on the single write cycle of a word
//            waddr      out  byte address of the word being written
//            wdata      out  word being written
//            busy       out  frame in progress (LEN_LO..CSUM)
//            done       out  sticky successful-load flag
//            err        out  error flag, cleared by the next sync byte
// Revision : 1.0  initial release
// ============================================================================
module uart_imem_loader #(
    parameter int          CLK_HZ      = 27_000_000,
    parameter int          BAUD        = 115_200,
    parameter int          MAX_WORDS   = 2048,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int          TIMEOUT_CYC = 16 * (CLK_HZ / BAUD) * 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        core_hold,
    output logic [3:0]  wstrb,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_div = CLK_HZ / BAUD;
    localparam int c_cw  = (c_div > 2) ? $clog2(c_div) : 1;
    localparam int c_tw  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [c_cw-1:0] c_div_m1  = c_cw'(c_div - 1);
    localparam logic [c_cw-1:0] c_half_m1 = c_cw'(c_div / 2 - 1);
    localparam logic [c_tw-1:0] c_tmo     = c_tw'(TIMEOUT_CYC);
    localparam logic [16:0]     c_max_words = 17'(MAX_WORDS);

    // Receiver states
    localparam logic [1:0] c_rx_idle  = 2'd0;
    localparam logic [1:0] c_rx_start = 2'd1;
    localparam logic [1:0] c_rx_data  = 2'd2;
    localparam logic [1:0] c_rx_stop  = 2'd3;

    // Frame states
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_len_lo = 3'd1;
    localparam logic [2:0] c_st_len_hi = 3'd2;
    localparam logic [2:0] c_st_data   = 3'd3;
    localparam logic [2:0] c_st_csum   = 3'd4;
    localparam logic [2:0] c_st_done   = 3'd5;
    localparam logic [2:0] c_st_err    = 3'd6;

    // ------------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------------
    logic            r_rx_s1;
    logic            r_rx_s2;
    logic            r_rx_prev;
    logic [1:0]      r_rx_state;
    logic [c_cw-1:0] r_bit_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_byte_valid;
    logic            r_frame_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_s1      <= 1'b1;
            r_rx_s2      <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_state   <= c_rx_idle;
            r_bit_cnt    <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_s1      <= uart_rx;
            r_rx_s2      <= r_rx_s1;
            r_rx_prev    <= r_rx_s2;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_rx_state)
                c_rx_idle: begin
                    // Only a genuine high-to-low transition starts a byte, so a
                    // line left low by a broken stop bit is not re-triggered.
                    if (r_rx_prev && !r_rx_s2) begin
                        r_rx_state <= c_rx_start;
                        r_bit_cnt  <= '0;
                    end
                end
                c_rx_start: begin
                    if (r_bit_cnt == c_half_m1) begin
                        r_bit_cnt <= '0;
                        if (r_rx_s2) begin
                            // Start bit gone by mid-bit: treat as a glitch.
                            r_rx_state <= c_rx_idle;
                        end else begin
                            r_rx_state <= c_rx_data;
                            r_bit_idx  <= 3'd0;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                c_rx_data: begin
                    if (r_bit_cnt == c_div_m1) begin
                        r_bit_cnt <= '0;
                        r_shift   <= {r_rx_s2, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_rx_state <= c_rx_stop;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_bit_cnt == c_div_m1) begin
                        r_bit_cnt  <= '0;
                        r_rx_state <= c_rx_idle;
                        if (r_rx_s2) begin
                            r_byte_valid <= 1'b1;
                        end else begin
                            r_frame_err  <= 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Frame parser and imem writer
    // ------------------------------------------------------------------------
    logic [2:0]      r_state;
    logic [15:0]     r_len;
    logic [15:0]     r_word_idx;
    logic [1:0]      r_byte_idx;
    logic [7:0]      r_sum;
    logic [c_tw-1:0] r_tmo_cnt;
    logic [3:0]      r_wstrb;
    logic [31:0]     r_waddr;
    logic [31:0]     r_wdata;
    logic            r_done;
    logic            r_err;
    logic            r_core_hold;

    logic            w_busy;
    logic            w_tmo_hit;
    logic [15:0]     w_len;

    assign w_busy    = (r_state == c_st_len_lo) || (r_state == c_st_len_hi) ||
                       (r_state == c_st_data)   || (r_state == c_st_csum);
    // The counter holds the number of cycles elapsed since the last received
    // byte; the hit fires on the cycle that count would reach the limit.
    assign w_tmo_hit = ((r_tmo_cnt + c_tw'(1)) == c_tmo);
    assign w_len     = {r_shift, r_len[7:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_len       <= 16'd0;
            r_word_idx  <= 16'd0;
            r_byte_idx  <= 2'd0;
            r_sum       <= 8'h00;
            r_tmo_cnt   <= '0;
            r_wstrb     <= 4'h0;
            r_waddr     <= 32'h0;
            r_wdata     <= 32'h0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_core_hold <= 1'b1;
        end else begin
            r_wstrb <= 4'h0;

            if (r_byte_valid) begin
                r_tmo_cnt <= c_tw'(1);
            end else if (w_busy) begin
                r_tmo_cnt <= r_tmo_cnt + c_tw'(1);
            end

            case (r_state)
                c_st_idle: begin
                    if (r_byte_valid && (r_shift == SYNC_BYTE)) begin
                        r_state <= c_st_len_lo;
                    end
                end
                c_st_done: begin
                    // Load complete; the receiver keeps running but is ignored.
                end
                c_st_err: begin
                    if (r_byte_valid && (r_shift == SYNC_BYTE)) begin
                        r_err   <= 1'b0;
                        r_state <= c_st_len_lo;
                    end
                end
                default: begin
                    if (r_frame_err || (!r_byte_valid && w_tmo_hit)) begin
                        r_state     <= c_st_err;
                        r_err       <= 1'b1;
                        r_core_hold <= 1'b1;
                    end else if (r_byte_valid) begin
                        case (r_state)
                            c_st_len_lo: begin
                                r_len[7:0] <= r_shift;
                                r_state    <= c_st_len_hi;
                            end
                            c_st_len_hi: begin
                                // Length is validated before any write, so
                                // word_idx can never run past the memory.
                                if ((w_len == 16'd0) || ({1'b0, w_len} > c_max_words)) begin
                                    r_state     <= c_st_err;
                                    r_err       <= 1'b1;
                                    r_core_hold <= 1'b1;
                                end else begin
                                    r_len      <= w_len;
                                    r_word_idx <= 16'd0;
                                    r_byte_idx <= 2'd0;
                                    r_sum      <= 8'h00;
                                    r_state    <= c_st_data;
                                end
                            end
                            c_st_data: begin
                                r_wdata[{r_byte_idx, 3'b000} +: 8] <= r_shift;
                                r_sum      <= r_sum + r_shift;
                                r_byte_idx <= r_byte_idx + 1'b1;
                                if (r_byte_idx == 2'd3) begin
                                    r_wstrb    <= 4'hF;
                                    r_waddr    <= {14'd0, r_word_idx, 2'b00};
                                    r_word_idx <= r_word_idx + 16'd1;
                                    if (r_word_idx == (r_len - 16'd1)) begin
                                        r_state <= c_st_csum;
                                    end
                                end
                            end
                            c_st_csum: begin
                                if (r_shift == r_sum) begin
                                    r_state     <= c_st_done;
                                    r_done      <= 1'b1;
                                    r_core_hold <= 1'b0;
                                end else begin
                                    r_state     <= c_st_err;
                                    r_err       <= 1'b1;
                                    r_core_hold <= 1'b1;
                                end
                            end
                            default: begin
                                r_state <= c_st_idle;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign core_hold = r_core_hold;
    assign wstrb     = r_wstrb;
    assign waddr     = r_waddr;
    assign wdata     = r_wdata;
    assign busy      = w_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire
